// File: rtl/crtc_timing.sv
// CRTC video timing: programmable hsync/vsync/de plus memory and raster addresses.
// Counters step on clk edges with cen=1, register writes land on the next clk edge; no backpressure.
module crtc_timing (
  input  logic        clk,
  input  logic        int_reset,
  input  logic        cen,
  input  logic        cs_n,
  input  logic        rs,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [13:0] ma,
  output logic [4:0]  ra
);
  typedef enum logic {V_NORMAL, V_ADJUST} vstate_t;

  logic [4:0]  addr_q;
  logic [7:0]  r0_q, r1_q, r2_q, r3_q, r13_q;
  logic [6:0]  r4_q, r6_q, r7_q;
  logic [4:0]  r5_q, r9_q;
  logic [5:0]  r12_q;

  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  rc_q, rc_d, adj_q, adj_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [13:0] row_q, row_d;
  vstate_t     state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [3:0]  hs_left_q, hs_left_d, vs_left_q, vs_left_d;
  logic        eol, new_frame;

  always_ff @(posedge clk or posedge int_reset) begin
    if (int_reset) begin
      addr_q <= '0;
      r0_q   <= '0; r1_q  <= '0; r2_q  <= '0; r3_q  <= '0;
      r4_q   <= '0; r5_q  <= '0; r6_q  <= '0; r7_q  <= '0;
      r9_q   <= '0; r12_q <= '0; r13_q <= '0;
    end else if (!cs_n && !wr_n) begin
      if (!rs) begin
        addr_q <= din[4:0];
      end else begin
        case (addr_q)
          5'd0:    r0_q  <= din;
          5'd1:    r1_q  <= din;
          5'd2:    r2_q  <= din;
          5'd3:    r3_q  <= din;
          5'd4:    r4_q  <= din[6:0];
          5'd5:    r5_q  <= din[4:0];
          5'd6:    r6_q  <= din[6:0];
          5'd7:    r7_q  <= din[6:0];
          5'd9:    r9_q  <= din[4:0];
          5'd12:   r12_q <= din[5:0];
          5'd13:   r13_q <= din;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge int_reset) begin
    if (int_reset) begin
      hcc_q     <= '0;
      rc_q      <= '0;
      vcc_q     <= '0;
      adj_q     <= '0;
      row_q     <= '0;
      state_q   <= V_NORMAL;
      hs_q      <= 1'b0;
      hs_left_q <= '0;
      vs_q      <= 1'b0;
      vs_left_q <= '0;
    end else begin
      hcc_q     <= hcc_d;
      rc_q      <= rc_d;
      vcc_q     <= vcc_d;
      adj_q     <= adj_d;
      row_q     <= row_d;
      state_q   <= state_d;
      hs_q      <= hs_d;
      hs_left_q <= hs_left_d;
      vs_q      <= vs_d;
      vs_left_q <= vs_left_d;
    end
  end

  always_comb begin
    hcc_d     = hcc_q;
    rc_d      = rc_q;
    vcc_d     = vcc_q;
    adj_d     = adj_q;
    row_d     = row_q;
    state_d   = state_q;
    hs_d      = hs_q;
    hs_left_d = hs_left_q;
    vs_d      = vs_q;
    vs_left_d = vs_left_q;
    new_frame = 1'b0;
    // R0==0 pins hcc at zero, so every character is the last one of its line
    eol = cen && ((hcc_q == r0_q) || (r0_q == 8'd0));

    if (cen) begin
      hcc_d = eol ? 8'd0 : hcc_q + 8'd1;
      if (hs_q) begin
        if (hs_left_q == 4'd0) hs_d = 1'b0;
        else hs_left_d = hs_left_q - 4'd1;
      end else if ((hcc_d == r2_q) && (r3_q[3:0] != 4'd0)) begin
        hs_d      = 1'b1;
        hs_left_d = r3_q[3:0] - 4'd1;
      end
    end

    if (eol) begin
      if (rc_q == r9_q) begin
        rc_d  = 5'd0;
        vcc_d = vcc_q + 7'd1;
        row_d = row_q + {6'd0, r1_q};
      end else begin
        rc_d = rc_q + 5'd1;
      end

      case (state_q)
        V_NORMAL: begin
          if ((vcc_q == r4_q) && (rc_q == r9_q)) begin
            if (r5_q == 5'd0) begin
              new_frame = 1'b1;
            end else begin
              state_d = V_ADJUST;
              adj_d   = 5'd0;
            end
          end
        end
        V_ADJUST: begin
          if (adj_q == r5_q - 5'd1) new_frame = 1'b1;
          else adj_d = adj_q + 5'd1;
        end
        default: ;
      endcase

      if (new_frame) begin
        vcc_d   = 7'd0;
        rc_d    = 5'd0;
        state_d = V_NORMAL;
        row_d   = {r12_q, r13_q};
      end

      // a programmed width of 0 wraps to 15 remaining lines, i.e. 16 lines total
      if (vs_q) begin
        if (vs_left_q == 4'd0) vs_d = 1'b0;
        else vs_left_d = vs_left_q - 4'd1;
      end else if ((state_d == V_NORMAL) && (vcc_d == r7_q) && (rc_d == 5'd0)) begin
        vs_d      = 1'b1;
        vs_left_d = r3_q[7:4] - 4'd1;
      end
    end
  end

  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de    = (hcc_q < r1_q) && (vcc_q < r6_q) && (state_q == V_NORMAL);
  assign ma    = row_q + {6'd0, hcc_q};
  assign ra    = rc_q;
endmodule

// File: tb/tb_crtc_timing.sv
// Bench for crtc_timing: directed frame-geometry checks plus randomized register traffic
// against a behavioural character-by-character model.
module tb_crtc_timing;
  logic        clk = 1'b0;
  logic        int_reset, cen, cs_n, rs, wr_n;
  logic [7:0]  din;
  logic        hsync, vsync, de;
  logic [13:0] ma;
  logic [4:0]  ra;

  crtc_timing dut (
    .clk(clk), .int_reset(int_reset), .cen(cen), .cs_n(cs_n), .rs(rs), .wr_n(wr_n),
    .din(din), .hsync(hsync), .vsync(vsync), .de(de), .ma(ma), .ra(ra)
  );

  always #5 clk = ~clk;

  localparam int F = 312 * 64;

  int n_checks = 0, n_errors = 0;
  int n = 0;
  bit mon_en = 0, nohs = 0, prev_vs = 0;
  int n_rises = 0, n_falls = 0, de_cnt = 0, hs_bad = 0;
  int rise_n[4], fall_n[4];
  int hs_first = -1, hs_last = -1;

  // reference model state
  int r[32];
  int m_addr, m_hcc, m_rc, m_vcc, m_row, m_adjn, m_hs, m_vs;
  bit m_adj;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (char %0d)", tag, got, exp, n);
      if (n_errors >= 40) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  endtask

  function automatic int reg_mask(input int a);
    case (a)
      0, 1, 2, 3, 13: return 255;
      4, 6, 7:        return 127;
      5, 9:           return 31;
      12:             return 63;
      default:        return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) r[i] = 0;
    m_addr = 0; m_hcc = 0; m_rc = 0; m_vcc = 0; m_row = 0;
    m_adjn = 0; m_hs = 0; m_vs = 0; m_adj = 0;
  endtask

  task automatic model_step();
    int nh;
    bit eol, nf;
    if (int_reset) begin
      model_reset();
      return;
    end
    if (cen) begin
      eol = (m_hcc == r[0]) || (r[0] == 0);
      nh  = eol ? 0 : (m_hcc + 1) % 256;
      // hsync: number of character periods still high
      if (m_hs > 0) m_hs--;
      else if (nh == r[2]) m_hs = r[3] % 16;
      if (eol) begin
        nf = 0;
        if (m_adj) begin
          if (m_adjn == (r[5] + 31) % 32) nf = 1;
          else m_adjn = (m_adjn + 1) % 32;
        end else if (m_vcc == r[4] && m_rc == r[9]) begin
          if (r[5] == 0) nf = 1;
          else begin m_adj = 1; m_adjn = 0; end
        end
        if (m_rc == r[9]) begin
          m_rc = 0; m_vcc = (m_vcc + 1) % 128; m_row = (m_row + r[1]) % 16384;
        end else begin
          m_rc = (m_rc + 1) % 32;
        end
        if (nf) begin
          m_rc = 0; m_vcc = 0; m_adj = 0; m_row = r[12] * 256 + r[13];
        end
        // vsync: number of lines still high
        if (m_vs > 0) m_vs--;
        else if (!m_adj && m_vcc == r[7] && m_rc == 0) m_vs = (r[3] / 16 == 0) ? 16 : r[3] / 16;
      end
      m_hcc = nh;
    end
    if (!cs_n && !wr_n) begin
      if (!rs) m_addr = din % 32;
      else if (reg_mask(m_addr) >= 0) r[m_addr] = din & reg_mask(m_addr);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [21:0] exp;
    exp = {m_hs > 0, m_vs > 0, (m_hcc < r[1]) && (m_vcc < r[6]) && !m_adj,
           14'((m_row + m_hcc) % 16384), 5'(m_rc)};
    check_val(tag, {10'd0, hsync, vsync, de, ma, ra}, {10'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (cen && !int_reset) n++;
    @(negedge clk);
    compare_all("outputs");
    if (mon_en) begin
      if (vsync && !prev_vs && n_rises < 4) begin rise_n[n_rises] = n; n_rises++; end
      if (!vsync && prev_vs && n_falls < 4) begin fall_n[n_falls] = n; n_falls++; end
      if (n_rises == 1) de_cnt += int'(de);
      if (nohs && hsync) hs_bad++;
    end
    prev_vs = vsync;
  endtask

  task automatic wr_reg(input int a, input int v);
    cs_n = 0; wr_n = 0; rs = 0; din = a[7:0];
    tick();
    rs = 1; din = v[7:0];
    tick();
    cs_n = 1; wr_n = 1; rs = 0;
  endtask

  initial begin
    int guard, a;
    int_reset = 1; cen = 0; cs_n = 1; rs = 0; wr_n = 1; din = 8'h00;
    model_reset();
    tick();
    tick();
    check_val("rst_hsync", hsync, 0);
    check_val("rst_vsync", vsync, 0);
    check_val("rst_de", de, 0);
    check_val("rst_ma", ma, 0);
    check_val("rst_ra", ra, 0);
    int_reset = 0;

    // reference display geometry, programmed with the character clock stopped
    wr_reg(0, 63);  wr_reg(1, 40);  wr_reg(2, 46);  wr_reg(3, 8'h8E);
    wr_reg(4, 38);  wr_reg(5, 0);   wr_reg(6, 25);  wr_reg(7, 30);
    wr_reg(9, 7);   wr_reg(12, 8'h30); wr_reg(13, 0);
    cen = 1; n = 0; mon_en = 1; prev_vs = vsync;
    guard = 0;
    while (n_falls < 3 && guard < 60000) begin
      guard++;
      if (n == F) begin
        check_val("ma_frame1", ma, 14'h3000);
        check_val("ra_frame1", ra, 0);
      end
      if (n == F + 3) check_val("de_line0", de, 1);
      if (n == F + 8 * 64) check_val("ma_row1", ma, 14'h3028);
      if (n >= F && n < F + 9 * 64 && (n - F) % 64 == 5) check_val("ra_cycle", ra, ((n - F) / 64) % 8);
      if (n >= F + 64 && n < F + 128 && hsync) begin
        if (hs_first < 0) hs_first = n - F - 64;
        hs_last = n - F - 64;
      end
      if (n == F + 128) begin
        check_val("hs_first", hs_first, 46);
        check_val("hs_last", hs_last, 59);
      end
      if (n == F + 199 * 64 + 39) check_val("de_last_on", de, 1);
      if (n == F + 199 * 64 + 40) check_val("de_hcc40", de, 0);
      if (n == F + 200 * 64) check_val("de_line200", de, 0);
      if (n == F + 240 * 64) begin
        wr_reg(5, 2);
        wr_reg(3, 0);
        nohs = 1;
      end
      if (n == F + 312 * 64 + 5) begin
        check_val("adj_de", de, 0);
        check_val("adj_vsync", vsync, 0);
      end
      if (n == F + 314 * 64) check_val("ma_frame2", ma, 14'h3000);
      tick();
    end
    mon_en = 0;
    check_val("vs_count", n_falls, 3);
    check_val("vs_rise_line", rise_n[0], 240 * 64);
    check_val("vs_len8", fall_n[0] - rise_n[0], 8 * 64);
    check_val("frame_312", rise_n[1] - rise_n[0], 312 * 64);
    check_val("frame_314", rise_n[2] - rise_n[1], 314 * 64);
    check_val("vs_len16", fall_n[2] - rise_n[2], 16 * 64);
    check_val("de_count", de_cnt, 40 * 200);
    check_val("hs_none", hs_bad, 0);

    // asynchronous reset while hsync is high
    wr_reg(3, 8'h8E);
    guard = 0;
    while (!hsync && guard < 200) begin guard++; tick(); end
    check_val("rst_hs_seen", hsync, 1);
    int_reset = 1;
    model_reset();
    #1;
    check_val("arst_hsync", hsync, 0);
    check_val("arst_ma", ma, 0);
    check_val("arst_ra", ra, 0);
    cen = 0;
    tick();
    tick();
    int_reset = 0;
    // data write without an address write must land in R0
    cs_n = 0; wr_n = 0; rs = 1; din = 8'd5;
    tick();
    cs_n = 1; wr_n = 1; rs = 0; cen = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) check_val("r0_after_rst", ma, 5);
      if (k == 6) check_val("r0_wrap", ma, 0);
    end
    check_val("r1_cleared_de", de, 0);

    // randomized traffic: character enables, register writes, reset pulses
    for (int i = 0; i < 12000; i++) begin
      cen = ($urandom % 4) != 0;
      if ($urandom % 12 == 0) begin
        cs_n = ($urandom % 8) == 0;
        wr_n = 0;
        rs = $urandom % 2;
        a = $urandom % 16;
        if (!rs) din = 8'(($urandom % 8) * 32 + a);
        else din = ($urandom % 6 == 0) ? 8'($urandom) : 8'($urandom % 9);
      end else begin
        cs_n = $urandom % 2; wr_n = 1; rs = $urandom % 2; din = 8'($urandom);
      end
      if (int_reset) int_reset = 0;
      else if ($urandom % 1500 == 0) begin
        int_reset = 1;
        model_reset();
        #1;
        compare_all("rand_arst");
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/crtc_timing.md
CRTC_TIMING -- requirements
Module: crtc_timing

Interface
REQ-001 SHALL have parameter: none; all timing comes from the programmable registers below.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: int_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cen  input  1  character-clock enable; counters advance only on clk edges with cen=1.
REQ-005 SHALL have port: cs_n  input  1  chip select, active-low.
REQ-006 SHALL have port: rs  input  1  0 = address register, 1 = data register.
REQ-007 SHALL have port: wr_n  input  1  write strobe, active-low, sampled every clk independent of cen.
REQ-008 SHALL have port: din  input  8  write data.
REQ-009 SHALL have port: hsync  output  1  horizontal sync, feeds gate-array HSYNC_I.
REQ-010 SHALL have port: vsync  output  1  vertical sync, feeds gate-array VSYNC_I.
REQ-011 SHALL have port: de  output  1  display enable.
REQ-012 SHALL have port: ma  output  14  memory address.
REQ-013 SHALL have port: ra  output  5  raster address.

Function
REQ-014 SHALL latch din[4:0] into a 5-bit address register on any clk with cs_n=0, rs=0, wr_n=0.
REQ-015 SHALL write din into the addressed register on any clk with cs_n=0, rs=1, wr_n=0, masked to width: R0 8, R1 8, R2 8, R3 8, R4 7, R5 5, R6 7, R7 7, R9 5, R12 6, R13 8; writes to other addresses are ignored.
REQ-016 SHALL make a register write visible on the next clk edge, including mid-line and mid-frame.
REQ-017 SHALL keep horizontal counter hcc (8 bit): on cen, hcc==R0 -> 0 (end of line), else hcc+1.
REQ-018 SHALL keep raster counter rc (5 bit): at end of line, rc==R9 -> 0 and vcc+1, else rc+1.
REQ-019 SHALL keep vertical counter vcc (7 bit) with states NORMAL and ADJUST: end of line with vcc==R4, rc==R9 -> new frame if R5==0, else ADJUST with adjust counter 0.
REQ-020 SHALL, in ADJUST, count lines; at end of line with adjust counter==R5-1 -> new frame; rc continues incrementing during ADJUST.
REQ-021 SHALL, at new frame, set vcc=0, rc=0, state NORMAL, row address = {R12,R13}.
REQ-022 SHALL assert hsync on the cen edge where hcc becomes R2, holding it R3[3:0] cen periods; R3[3:0]=0 produces no hsync.
REQ-023 SHALL assert vsync at start of line when vcc==R7 and rc==0 in NORMAL, holding it R3[7:4] lines (0 means 16).
REQ-024 SHALL ignore a new hsync/vsync start condition while that sync is already active.
REQ-025 SHALL drive de=1 iff hcc<R1, vcc<R6, state NORMAL.
REQ-026 SHALL drive ma = row address + hcc (14-bit wrap) and ra = rc.
REQ-027 SHALL add R1 to the row address (14-bit wrap) at end of line when rc==R9.
REQ-028 SHALL, when R0==0, hold hcc at 0 and treat every cen as end of line.
REQ-029 SHALL, when a counter already exceeds its newly written limit, count up to 8/7/5-bit wrap before matching.

Reset
REQ-030 SHALL, while int_reset=1, hold all registers, counters, address register and state at 0/NORMAL, and drive hsync=0, vsync=0, de=0, ma=0, ra=0.
REQ-031 SHALL resume counting on the first cen after int_reset deasserts, from hcc=vcc=rc=0.

Verification
REQ-032 SHALL pass: program R0=63,R1=40,R2=46,R3=0x8E,R4=38,R5=0,R6=25,R7=30,R9=7,R12=0x30,R13=0 -> line 64 cen, hsync high hcc 46..59, frame 312 lines.
REQ-033 SHALL pass: same setup -> vsync rises at line 240 of frame, lasts 8 lines; de high for hcc 0..39 of lines 0..199.
REQ-034 SHALL pass: same setup -> ma=0x3000 at frame start, 0x3028 on char row 1 at hcc=0, ra cycles 0..7.
REQ-035 SHALL pass: R5=2 -> frame 314 lines, de=0 and vsync unaffected during the 2 ADJUST lines.
REQ-036 SHALL pass: R3=0x00 -> hsync never asserts, vsync lasts 16 lines.
REQ-037 SHALL pass: int_reset pulse mid-line with hsync high -> all outputs 0 immediately, registers cleared, address register 0.
